// File: rtl/batcharger_pkg.sv
// Shared types and default constants for the battery charge controller.
package batcharger_pkg;

  localparam int DEF_W        = 8;
  localparam int DEF_VCUTOFF  = 150;
  localparam int DEF_VPRESET  = 210;
  localparam int DEF_VRECHG   = 200;
  localparam int DEF_TEMP_MIN = 40;
  localparam int DEF_TEMP_MAX = 200;
  localparam int DEF_DEBOUNCE = 3;
  localparam int DEF_CC_STEP  = 12;
  localparam int DEF_CV_TMAX  = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TC,
    CC,
    CV,
    DONE
  } state_t;

endpackage

// File: rtl/batcharger_debounce.sv
// Counts consecutive qualifying samples; qualified fires on the sample that
// completes the required run.
module batcharger_debounce
  import batcharger_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic smp_valid,
  input  logic cond,
  input  logic clear,
  output logic qualified
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (smp_valid) begin
      if (!cond)
        cnt <= '0;
      else if (cnt != SAT)
        cnt <= cnt + CW'(1);
    end
  end

  assign qualified = smp_valid && cond && (cnt >= LAST);

endmodule

// File: rtl/batcharger_ctrl.sv
// Trickle / constant-current / constant-voltage charge sequencer driving the
// analog front-end current code, voltage target and mode flags.
module batcharger_ctrl
  import batcharger_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int VCUTOFF  = DEF_VCUTOFF,
  parameter int VPRESET  = DEF_VPRESET,
  parameter int VRECHG   = DEF_VRECHG,
  parameter int TEMP_MIN = DEF_TEMP_MIN,
  parameter int TEMP_MAX = DEF_TEMP_MAX,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int CC_STEP  = DEF_CC_STEP,
  parameter int CV_TMAX  = DEF_CV_TMAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [3:0]   sel,
  input  logic         smp_valid,
  input  logic [W-1:0] vbat_code,
  input  logic [W-1:0] ibat_code,
  input  logic [W-1:0] vtemp_code,
  output logic [W-1:0] ictrl,
  output logic [W-1:0] vtarget,
  output logic         tc,
  output logic         cc,
  output logic         cv,
  output logic         done
);

  localparam logic [W-1:0] VCUT_C = W'(VCUTOFF);
  localparam logic [W-1:0] VPRE_C = W'(VPRESET);
  localparam logic [W-1:0] VRCH_C = W'(VRECHG);
  localparam logic [W-1:0] TMIN_C = W'(TEMP_MIN);
  localparam logic [W-1:0] TMAX_C = W'(TEMP_MAX);
  localparam int TW = (CV_TMAX > 1) ? $clog2(CV_TMAX) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CV_TMAX - 1);

  state_t        state, state_d;
  logic [3:0]    sel_q;
  logic [TW-1:0] cv_timer;
  logic [W-1:0]  icc, itc, iend;
  logic          temp_ok, fault, cv_expired;
  logic          db_cond, db_clear, qualified;
  logic [W-1:0]  ictrl_d, vtarget_d;
  logic          tc_d, cc_d, cv_d, done_d;

  assign icc        = W'((int'(sel_q) + 1) * CC_STEP);
  assign itc        = icc >> 3;
  assign iend       = icc >> 4;
  assign temp_ok    = (vtemp_code >= TMIN_C) && (vtemp_code <= TMAX_C);
  assign fault      = smp_valid && !temp_ok;
  assign cv_expired = (state == CV) && (cv_timer == TLAST);
  assign db_clear   = (state_d != state);

  // One shared qualifier; the condition it watches depends on the state.
  always_comb begin
    db_cond = 1'b0;
    case (state)
      TC:      db_cond = (vbat_code >= VCUT_C);
      CC:      db_cond = (vbat_code >= VPRE_C);
      CV:      db_cond = (ibat_code <= iend);
      DONE:    db_cond = (vbat_code < VRCH_C);
      default: db_cond = 1'b0;
    endcase
  end

  batcharger_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .smp_valid(smp_valid),
    .cond     (db_cond),
    .clear    (db_clear),
    .qualified(qualified)
  );

  always_comb begin
    state_d = state;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:  state_d = START;
        START: begin
          if (smp_valid && temp_ok) begin
            if (vbat_code < VCUT_C)      state_d = TC;
            else if (vbat_code < VPRE_C) state_d = CC;
            else                         state_d = DONE;
          end
        end
        TC: begin
          if (fault)          state_d = START;
          else if (qualified) state_d = CC;
        end
        CC: begin
          if (fault)          state_d = START;
          else if (qualified) state_d = CV;
        end
        CV: begin
          if (fault)                        state_d = START;
          else if (qualified || cv_expired) state_d = DONE;
        end
        DONE:    if (qualified) state_d = START;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output values are decoded from the next state so they move with it.
  always_comb begin
    ictrl_d   = '0;
    vtarget_d = '0;
    tc_d      = 1'b0;
    cc_d      = 1'b0;
    cv_d      = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      TC: begin
        ictrl_d = itc;
        tc_d    = 1'b1;
      end
      CC: begin
        ictrl_d = icc;
        cc_d    = 1'b1;
      end
      CV: begin
        ictrl_d   = icc;
        vtarget_d = VPRE_C;
        cv_d      = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      cv_timer <= '0;
      ictrl    <= '0;
      vtarget  <= '0;
      tc       <= 1'b0;
      cc       <= 1'b0;
      cv       <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_d;
      ictrl   <= ictrl_d;
      vtarget <= vtarget_d;
      tc      <= tc_d;
      cc      <= cc_d;
      cv      <= cv_d;
      done    <= done_d;
      if (state == IDLE && state_d == START)
        sel_q <= sel;
      if (state_d == CV && state != CV)
        cv_timer <= '0;
      else if (state == CV && cv_timer != TLAST)
        cv_timer <= cv_timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Scoreboard bench: a behavioural charge-sequence model predicts outputs per
// edge; a negedge monitor pops and compares.
module tb_batcharger_ctrl;

  localparam int TMAX = 100;

  logic       clk = 1'b0;
  logic       rst, en, smp_valid;
  logic [3:0] sel;
  logic [7:0] vbat_code, ibat_code, vtemp_code;
  logic [7:0] ictrl, vtarget;
  logic       tc, cc, cv, done;

  always #5 clk = ~clk;

  batcharger_ctrl #(
    .CV_TMAX(TMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sel       (sel),
    .smp_valid (smp_valid),
    .vbat_code (vbat_code),
    .ibat_code (ibat_code),
    .vtemp_code(vtemp_code),
    .ictrl     (ictrl),
    .vtarget   (vtarget),
    .tc        (tc),
    .cc        (cc),
    .cv        (cv),
    .done      (done)
  );

  typedef struct {
    int ictrl;
    int vtarget;
    bit tc, cc, cv, done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_edge  = 0;

  // Behavioural model: charge phase, latched capacity, qualifying run length,
  // and number of edges spent in CV.
  localparam int M_IDLE = 0, M_START = 1, M_TC = 2, M_CC = 3, M_CV = 4, M_DONE = 5;
  int m_mode = M_IDLE;
  int m_sel  = 0;
  int m_run  = 0;
  int m_age  = 0;
  logic [3:0] cur_sel = 4'd0;

  function automatic int cap_current(int s);
    return ((s + 1) * 12) % 256;
  endfunction

  function automatic void model_edge();
    int nxt;
    bit tok, hit;
    int vb, ib, vt;
    vb = int'(vbat_code);
    ib = int'(ibat_code);
    vt = int'(vtemp_code);
    if (rst) begin
      m_mode = M_IDLE; m_sel = 0; m_run = 0; m_age = 0;
      return;
    end
    nxt = m_mode;
    tok = (vt >= 40) && (vt <= 200);
    if (!en) begin
      nxt = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      nxt = M_START;
      m_sel = int'(sel);
    end else if (m_mode == M_START) begin
      if (smp_valid && tok) nxt = (vb < 150) ? M_TC : (vb < 210) ? M_CC : M_DONE;
    end else if (smp_valid && !tok && m_mode != M_DONE) begin
      nxt = M_START;
    end else begin
      if (smp_valid) begin
        case (m_mode)
          M_TC:    hit = (vb >= 150);
          M_CC:    hit = (vb >= 210);
          M_CV:    hit = (ib <= cap_current(m_sel) / 16);
          default: hit = (vb < 200);
        endcase
        m_run = hit ? m_run + 1 : 0;
      end
      if (m_run >= 3) begin
        case (m_mode)
          M_TC:    nxt = M_CC;
          M_CC:    nxt = M_CV;
          M_CV:    nxt = M_DONE;
          default: nxt = M_START;
        endcase
      end
      if (m_mode == M_CV && m_age + 1 == TMAX) nxt = M_DONE;
    end
    if (m_mode == M_CV) m_age++;
    if (nxt != m_mode) begin
      m_run = 0;
      if (nxt == M_CV) m_age = 0;
    end
    m_mode = nxt;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   icc;
    icc = cap_current(m_sel);
    e.ictrl   = (m_mode == M_TC) ? icc / 8 : (m_mode == M_CC || m_mode == M_CV) ? icc : 0;
    e.vtarget = (m_mode == M_CV) ? 210 : 0;
    e.tc   = (m_mode == M_TC);
    e.cc   = (m_mode == M_CC);
    e.cv   = (m_mode == M_CV);
    e.done = (m_mode == M_DONE);
    return e;
  endfunction

  task automatic step(input bit r, input bit e, input logic [3:0] s, input bit v,
                      input int vb, input int ib, input int vt);
    rst = r; en = e; sel = s; smp_valid = v;
    vbat_code = 8'(vb); ibat_code = 8'(ib); vtemp_code = 8'(vt);
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic sample(input int vb, input int ib, input int vt);
    step(1'b0, 1'b1, cur_sel, 1'b1, vb, ib, vt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_edge++;
      n_tests++;
      if (int'(ictrl) != e.ictrl || int'(vtarget) != e.vtarget ||
          tc !== e.tc || cc !== e.cc || cv !== e.cv || done !== e.done) begin
        n_fail++;
        $display("FAIL outputs edge %0d: got ictrl=%0d vtarget=%0d tc=%b cc=%b cv=%b done=%b, expected ictrl=%0d vtarget=%0d tc=%b cc=%b cv=%b done=%b",
                 n_edge, ictrl, vtarget, tc, cc, cv, done,
                 e.ictrl, e.vtarget, e.tc, e.cc, e.cv, e.done);
      end
      n_tests++;
      if ($countones({tc, cc, cv, done}) > 1) begin
        n_fail++;
        $display("FAIL onehot edge %0d: got flags %b, expected at most one set",
                 n_edge, {tc, cc, cv, done});
      end
    end
  end

  int vb_r, vt_r;

  initial begin
    step(1'b1, 1'b0, 4'd0, 1'b0, 0, 0, 120);
    step(1'b1, 1'b0, 4'd0, 1'b0, 0, 0, 120);

    cur_sel = 4'b1000;
    step(1'b0, 1'b1, cur_sel, 1'b0, 0, 0, 120);
    sample(100, 50, 120);
    for (int v = 100; v <= 220; v++) sample(v, 50, 120);
    sample(220, 5, 120);
    sample(220, 5, 120);
    sample(220, 20, 120);
    repeat (3) sample(220, 5, 120);

    repeat (3) sample(199, 50, 120);
    sample(205, 50, 120);
    cur_sel = 4'hF;
    repeat (3) sample(180, 50, 120);
    sample(180, 50, 250);
    sample(180, 50, 120);
    repeat (3) sample(215, 50, 120);
    repeat (110) step(1'b0, 1'b1, cur_sel, 1'($urandom_range(0, 1)), 215, 50, 120);

    repeat (3) sample(199, 50, 120);
    sample(180, 50, 120);
    step(1'b0, 1'b0, cur_sel, 1'b1, 180, 50, 120);
    step(1'b0, 1'b0, cur_sel, 1'b0, 180, 50, 120);

    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0:       vb_r = $urandom_range(0, 255);
        1:       vb_r = $urandom_range(145, 155);
        2:       vb_r = $urandom_range(195, 215);
        default: vb_r = $urandom_range(140, 230);
      endcase
      case ($urandom_range(0, 19))
        0:       vt_r = 39;
        1:       vt_r = 40;
        2:       vt_r = 200;
        3:       vt_r = 201;
        4:       vt_r = $urandom_range(0, 255);
        default: vt_r = $urandom_range(41, 199);
      endcase
      step(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 99) >= 2),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 6),
           vb_r, $urandom_range(0, 20), vt_r);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
